// File: rtl/force_stage_pkg.sv
// Shared types for the force/release override stage: command opcodes,
// FSM state encoding and default counter width.
package force_stage_pkg;

  typedef enum logic [1:0] {
    NOP         = 2'd0,
    FORCE       = 2'd1,
    RELEASE     = 2'd2,
    RELEASE_ALL = 2'd3
  } force_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FORCED = 2'd1,
    TIMED  = 2'd2
  } force_state_e;

  localparam int FORCE_CNT_W_DEFAULT = 8;

endpackage

// File: rtl/force_release_stage_if.sv
// Command channel of the force/release stage.
// Handshake: a command transfers on a rising clk edge where cmd_valid && cmd_ready;
// the master holds op/mask/value/hold stable while cmd_valid is high.
interface force_cmd_if
  import force_stage_pkg::*;
#(
  parameter int W     = 4,
  parameter int CNT_W = FORCE_CNT_W_DEFAULT
);
  logic             cmd_valid;
  logic             cmd_ready;
  force_op_e        cmd_op;
  logic [W-1:0]     cmd_mask;
  logic [W-1:0]     cmd_value;
  logic [CNT_W-1:0] cmd_hold;

  modport master (
    output cmd_valid, cmd_op, cmd_mask, cmd_value, cmd_hold,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_mask, cmd_value, cmd_hold,
    output cmd_ready
  );
endinterface

// File: rtl/force_hold_timer.sv
// Shared auto-release countdown: load wins over decrement, clear wins over load.
// expire is high in the cycle the count sits at 1.
module force_hold_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             expire
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
    if (load)        cnt_d = load_val;
    if (clear)       cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_l) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt    = cnt_q;
  assign expire = (cnt_q == CNT_W'(1));
endmodule

// File: rtl/force_release_stage.sv
// Per-bit force/release override on the driver side of a bus, with NET
// (revert to driver) or VAR (retain until next write) release semantics.
module force_release_stage
  import force_stage_pkg::*;
#(
  parameter int W      = 4,
  parameter bit IS_VAR = 1'b0,
  parameter int CNT_W  = FORCE_CNT_W_DEFAULT
) (
  input  logic          clk,
  input  logic          reset_l,
  input  logic [W-1:0]  drv_data,
  input  logic          drv_we,
  force_cmd_if.slave    cmd,
  output logic [W-1:0]  out_data,
  output logic [W-1:0]  forced_mask,
  output logic          timer_busy,
  output force_state_e  dbg_state
);
  logic [W-1:0]     fmask_q, fmask_d;
  logic [W-1:0]     fval_q, fval_d;
  logic [W-1:0]     var_q, var_d;
  logic [W-1:0]     tmask_q, tmask_d;
  force_state_e     state_q, state_d;

  logic [W-1:0]     rel_mask;
  logic [W-1:0]     keep_mask;
  logic             accept;
  logic             tmr_load;
  logic             tmr_clear;
  logic             tmr_expire;
  logic [CNT_W-1:0] tmr_cnt;

  assign cmd.cmd_ready = reset_l;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  // Ordering within a cycle: timer expiry, then the command, then the VAR write.
  always_comb begin
    fmask_d   = fmask_q;
    fval_d    = fval_q;
    var_d     = var_q;
    tmask_d   = tmask_q;
    rel_mask  = '0;
    keep_mask = '0;
    tmr_load  = 1'b0;
    tmr_clear = 1'b0;
    state_d   = state_q;

    if (tmr_expire) begin
      if (IS_VAR) var_d = (var_d & ~tmask_q) | (fval_q & tmask_q);
      fmask_d = fmask_d & ~tmask_q;
      tmask_d = '0;
    end

    if (accept) begin
      case (cmd.cmd_op)
        FORCE: begin
          fmask_d = fmask_d | cmd.cmd_mask;
          fval_d  = (fval_d & ~cmd.cmd_mask) | (cmd.cmd_value & cmd.cmd_mask);
          if (cmd.cmd_hold != '0) begin
            tmask_d  = tmask_d | cmd.cmd_mask;
            tmr_load = 1'b1;
          end else begin
            tmask_d = tmask_d & ~cmd.cmd_mask;
          end
        end
        RELEASE:     rel_mask = cmd.cmd_mask & fmask_d;
        RELEASE_ALL: rel_mask = fmask_d;
        default:     ;
      endcase
    end

    // Write protection covers bits forced before this cycle's command and
    // still forced after its release; newly forced bits are hidden anyway.
    keep_mask = fmask_d & ~rel_mask;
    if (accept && cmd.cmd_op == FORCE) keep_mask = (fmask_q & ~(tmr_expire ? tmask_q : '0)) & ~rel_mask;

    if (IS_VAR) var_d = (var_d & ~rel_mask) | (fval_d & rel_mask);
    fmask_d = fmask_d & ~rel_mask;
    tmask_d = tmask_d & ~rel_mask;

    if (IS_VAR && drv_we) var_d = (var_d & keep_mask) | (drv_data & ~keep_mask);

    if (fmask_d == '0) tmask_d = '0;
    tmr_clear = (tmask_d == '0);

    if (fmask_d == '0)      state_d = IDLE;
    else if (tmask_d != '0) state_d = TIMED;
    else                    state_d = FORCED;
  end

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      fmask_q <= '0;
      fval_q  <= '0;
      var_q   <= '0;
      tmask_q <= '0;
      state_q <= IDLE;
    end else begin
      fmask_q <= fmask_d;
      fval_q  <= fval_d;
      var_q   <= var_d;
      tmask_q <= tmask_d;
      state_q <= state_d;
    end
  end

  force_hold_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset_l  (reset_l),
    .clear    (tmr_clear),
    .load     (tmr_load),
    .load_val (cmd.cmd_hold),
    .cnt      (tmr_cnt),
    .expire   (tmr_expire)
  );

  assign out_data    = (fval_q & fmask_q) | ((IS_VAR ? var_q : drv_data) & ~fmask_q);
  assign forced_mask = fmask_q;
  assign timer_busy  = (state_q == TIMED);
  assign dbg_state   = state_q;
endmodule

// File: tb/tb_force_release_stage.sv
// Directed bench: one NET (W=4) and one VAR (W=32) instance sharing clock and reset.
module tb_force_release_stage;
  import force_stage_pkg::*;

  logic        clk;
  logic        reset_l;
  int          checks;
  int          errors;

  logic [3:0]  n_drv;
  logic [3:0]  n_out, n_fm;
  logic        n_busy;
  force_state_e n_st;

  logic [31:0] v_drv;
  logic        v_we;
  logic [31:0] v_out, v_fm;
  logic        v_busy;
  force_state_e v_st;

  force_cmd_if #(.W(4),  .CNT_W(8)) n_if ();
  force_cmd_if #(.W(32), .CNT_W(8)) v_if ();

  force_release_stage #(.W(4), .IS_VAR(1'b0), .CNT_W(8)) u_net (
    .clk(clk), .reset_l(reset_l), .drv_data(n_drv), .drv_we(1'b0), .cmd(n_if.slave),
    .out_data(n_out), .forced_mask(n_fm), .timer_busy(n_busy), .dbg_state(n_st)
  );

  force_release_stage #(.W(32), .IS_VAR(1'b1), .CNT_W(8)) u_var (
    .clk(clk), .reset_l(reset_l), .drv_data(v_drv), .drv_we(v_we), .cmd(v_if.slave),
    .out_data(v_out), .forced_mask(v_fm), .timer_busy(v_busy), .dbg_state(v_st)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n_if.cmd_valid = 1'b0;
    n_if.cmd_op    = NOP;
    v_if.cmd_valid = 1'b0;
    v_if.cmd_op    = NOP;
    v_we           = 1'b0;
  endtask

  task automatic n_cmd(input force_op_e op, input logic [3:0] mask, input logic [3:0] value,
                       input logic [7:0] hold);
    n_if.cmd_valid = 1'b1;
    n_if.cmd_op    = op;
    n_if.cmd_mask  = mask;
    n_if.cmd_value = value;
    n_if.cmd_hold  = hold;
  endtask

  task automatic v_cmd(input force_op_e op, input logic [31:0] mask, input logic [31:0] value,
                       input logic [7:0] hold);
    v_if.cmd_valid = 1'b1;
    v_if.cmd_op    = op;
    v_if.cmd_mask  = mask;
    v_if.cmd_value = value;
    v_if.cmd_hold  = hold;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_l = 1'b0;
    n_drv = 4'b0101;
    v_drv = '0;
    v_we  = 1'b0;
    n_if.cmd_valid = 1'b0; n_if.cmd_op = NOP; n_if.cmd_mask = '0; n_if.cmd_value = '0; n_if.cmd_hold = '0;
    v_if.cmd_valid = 1'b0; v_if.cmd_op = NOP; v_if.cmd_mask = '0; v_if.cmd_value = '0; v_if.cmd_hold = '0;

    step();
    step();
    check("n_ready_rst", 64'(n_if.cmd_ready), 64'd0);
    check("v_ready_rst", 64'(v_if.cmd_ready), 64'd0);
    reset_l = 1'b1;
    step();
    check("n_ready", 64'(n_if.cmd_ready), 64'd1);
    check("n_fm_rst",   64'(n_fm),   64'd0);
    check("n_busy_rst", 64'(n_busy), 64'd0);
    check("n_st_rst",   64'(n_st),   64'(IDLE));
    check("n_out_rst",  64'(n_out),  64'h5);
    check("v_out_rst",  64'(v_out),  64'h0);
    check("v_fm_rst",   64'(v_fm),   64'h0);

    // NET: full force, re-force, release all
    n_cmd(FORCE, 4'b1111, 4'b0111, 8'd0); step();
    check("n_force_all", 64'(n_out), 64'h7);
    check("n_st_forced", 64'(n_st),  64'(FORCED));
    n_cmd(FORCE, 4'b1111, 4'b1111, 8'd0); step();
    check("n_reforce", 64'(n_out), 64'hf);
    n_cmd(RELEASE_ALL, 4'b0000, 4'b0000, 8'd0); step();
    check("n_relall",    64'(n_out), 64'h5);
    check("n_relall_fm", 64'(n_fm),  64'h0);

    // NET: partial force and partial release
    n_cmd(FORCE, 4'b0011, 4'b0010, 8'd0); step();
    check("n_part",    64'(n_out), 64'h6);
    check("n_part_fm", 64'(n_fm),  64'h3);
    n_cmd(RELEASE, 4'b0001, 4'b0000, 8'd0); step();
    check("n_rel1",    64'(n_out), 64'h7);
    check("n_rel1_fm", 64'(n_fm),  64'h2);
    n_cmd(RELEASE_ALL, 4'b0000, 4'b0000, 8'd0); step();
    check("n_rel_rest", 64'(n_out), 64'h5);

    // NET: driver change shows combinationally on unforced bits
    n_cmd(FORCE, 4'b0011, 4'b0010, 8'd0); step();
    n_drv = 4'b1000;
    #1;
    check("n_drv_comb", 64'(n_out), 64'ha);
    n_cmd(RELEASE_ALL, 4'b0000, 4'b0000, 8'd0); step();
    check("n_drv_rel", 64'(n_out), 64'h8);
    n_drv = 4'b0101;

    // NET: release with nothing forced
    n_cmd(RELEASE, 4'b1111, 4'b0000, 8'd0); step();
    check("n_rel_none",    64'(n_out), 64'h5);
    check("n_rel_none_st", 64'(n_st),  64'(IDLE));

    // NET: timed force holds for exactly three cycles
    n_cmd(FORCE, 4'b1000, 4'b1000, 8'd3); step();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("n_timed_out%0d", i),  64'(n_out),  64'hd);
      check($sformatf("n_timed_busy%0d", i), 64'(n_busy), 64'd1);
      if (i < 2) step();
    end
    step();
    check("n_expired_out",  64'(n_out),  64'h5);
    check("n_expired_busy", 64'(n_busy), 64'd0);
    check("n_expired_st",   64'(n_st),   64'(IDLE));

    // NET: re-force at count 1 extends by three more cycles
    n_cmd(FORCE, 4'b1000, 4'b1000, 8'd3); step();
    step();
    step();
    check("n_ext_c1", 64'(n_out), 64'hd);
    n_cmd(FORCE, 4'b1000, 4'b1000, 8'd3); step();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("n_ext_out%0d", i),  64'(n_out),  64'hd);
      check($sformatf("n_ext_busy%0d", i), 64'(n_busy), 64'd1);
      if (i < 2) step();
    end
    step();
    check("n_ext_done",    64'(n_out), 64'h5);
    check("n_ext_done_st", 64'(n_st),  64'(IDLE));

    // VAR: write, empty release, force, retained release, next write
    v_drv = 32'h1538; v_we = 1'b1; step();
    check("v_write", 64'(v_out), 64'h1538);
    v_cmd(RELEASE, 32'h0000000f, 32'h0, 8'd0); step();
    check("v_rel_none",    64'(v_out), 64'h1538);
    check("v_rel_none_st", 64'(v_st),  64'(IDLE));
    v_cmd(FORCE, 32'hffffffff, 32'h0888, 8'd0); step();
    check("v_force", 64'(v_out), 64'h0888);
    v_cmd(RELEASE_ALL, 32'h0, 32'h0, 8'd0); step();
    check("v_retain",    64'(v_out), 64'h0888);
    check("v_retain_fm", 64'(v_fm),  64'h0);
    v_drv = 32'h5432; v_we = 1'b1; step();
    check("v_write2", 64'(v_out), 64'h5432);

    // VAR: writes to forced bits are discarded
    v_cmd(FORCE, 32'h0000000f, 32'h0, 8'd0); step();
    check("v_force_lo", 64'(v_out), 64'h5430);
    v_drv = 32'hffffffff; v_we = 1'b1; step();
    check("v_wr_forced", 64'(v_out), 64'hfffffff0);
    v_cmd(RELEASE_ALL, 32'h0, 32'h0, 8'd0); step();
    check("v_wr_discard", 64'(v_out), 64'hfffffff0);

    // VAR: same-cycle release and write, write wins on released bits
    v_cmd(FORCE, 32'h0000000f, 32'h5, 8'd0); step();
    check("v_force5", 64'(v_out), 64'hfffffff5);
    v_cmd(RELEASE, 32'h0000000f, 32'h0, 8'd0);
    v_drv = 32'h0000000a; v_we = 1'b1; step();
    check("v_rel_wr", 64'(v_out), 64'h0000000a);

    // Reset in the middle of a timed force
    n_cmd(FORCE, 4'b1000, 4'b1000, 8'd3);
    v_cmd(FORCE, 32'h00000004, 32'h4, 8'd3); step();
    check("n_pre_rst_busy", 64'(n_busy), 64'd1);
    check("v_pre_rst_out",  64'(v_out),  64'he);
    reset_l = 1'b0;
    step();
    check("n_mid_rst_fm",    64'(n_fm),    64'h0);
    check("n_mid_rst_busy",  64'(n_busy),  64'd0);
    check("n_mid_rst_ready", 64'(n_if.cmd_ready), 64'd0);
    check("n_mid_rst_out",   64'(n_out),   64'h5);
    check("v_mid_rst_out",   64'(v_out),   64'h0);
    check("v_mid_rst_busy",  64'(v_busy),  64'd0);
    check("v_mid_rst_ready", 64'(v_if.cmd_ready), 64'd0);
    reset_l = 1'b1;
    step();
    check("n_post_rst_st", 64'(n_st), 64'(IDLE));
    check("v_post_rst_st", 64'(v_st), 64'(IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/force_release_stage.md
Name: force_release_stage

Overview:
- Synthesizable force/release override stage on the driver side of a tristate-style data bus.
- Sits between a data source (`drv_data`) and the consumers of the bus.
- Applies per-bit force/release commands received over a valid/ready command port.
- Two behaviours, chosen at elaboration:
  - NET: after release, a bit reverts to its driver.
  - VAR: after release, a bit keeps the forced value until its next write.
- Optional timed auto-release.

Parameters:
- W, 4: data/bus width in bits; 1..64.
- IS_VAR, 0: 0 = NET semantics, 1 = VAR semantics.
- CNT_W, 8: width of the auto-release hold counter.

Ports:
- clk, input, 1: rising-edge clock.
- reset_l, input, 1: synchronous active-low reset.
- drv_data, input, W: driver value (the continuous assignment source for NET; write data for VAR).
- drv_we, input, 1: VAR write strobe; ignored when IS_VAR=0.
- cmd_valid, input, 1: command valid.
- cmd_ready, output, 1: command accepted when cmd_valid && cmd_ready.
- cmd_op, input, 2: command opcode; force_op_e from the package (NOP=0, FORCE=1, RELEASE=2, RELEASE_ALL=3).
- cmd_mask, input, W: bits affected by the command.
- cmd_value, input, W: force value; used only by FORCE.
- cmd_hold, input, CNT_W: FORCE only; 0 = force until released, N>0 = auto-release after N cycles.
- out_data, output, W: resolved bus value.
- forced_mask, output, W: bits currently forced.
- timer_busy, output, 1: auto-release countdown active.

Behaviour:
- Reset (reset_l=0 at a clk edge): fmask_q=0, fval_q=0, var_q=0, cnt_q=0, state=IDLE. Reset mid-force drops all forces immediately.
- cmd_ready: 0 while reset_l=0, otherwise 1. A command is accepted in any state.
- Out path:
  - NET: out_data = (fval_q & fmask_q) | (drv_data & ~fmask_q). Combinational from drv_data; a driver change shows in the same cycle.
  - VAR: out_data = (fval_q & fmask_q) | (var_q & ~fmask_q). Fully registered.
- VAR write: on drv_we, var_q <= (var_q & fmask_q) | (drv_data & ~fmask_q). Writes to forced bits are discarded, not deferred.
- FORCE accepted in cycle N: from N+1, fmask_q |= cmd_mask and fval_q bits under cmd_mask = cmd_value. A re-force of an already-forced bit overwrites its value.
- RELEASE accepted: fmask_q &= ~cmd_mask from N+1.
  - VAR: var_q takes fval_q on the released bits, so the value is retained.
  - NET: the released bits show drv_data.
- RELEASE of unforced bits: no-op, no error. RELEASE_ALL: same as RELEASE with cmd_mask = all ones.
- Same-cycle drv_we and RELEASE (VAR): the release retention is applied first, then the write, so the write wins on the released bits.
- FSM states:
  - IDLE: fmask_q==0.
  - FORCED: fmask_q!=0, no timer.
  - TIMED: timer running.
- FSM transitions:
  - FORCE with hold=0: go to FORCED.
  - FORCE with hold=N>0: load cnt_q=N, go to TIMED.
  - In TIMED, cnt_q decrements each cycle. When cnt_q==1, all timed bits (tmask_q) are released at the next edge; go to FORCED if other bits remain forced, else IDLE.
  - Any state: a release that leaves fmask_q==0 goes to IDLE and clears cnt_q and tmask_q.
- Timer edge cases:
  - A new timed FORCE while TIMED reloads cnt_q and ORs its bits into tmask_q (single shared timer).
  - An untimed FORCE while TIMED removes its bits from tmask_q.
  - Expiry and a command in the same cycle: the command is applied after expiry, so a FORCE in that cycle survives the expiry.
- timer_busy = (state==TIMED). forced_mask = fmask_q.

Decomposition:
- Package force_stage_pkg:
  - typedef enum logic[1:0] force_op_e (NOP, FORCE, RELEASE, RELEASE_ALL).
  - typedef enum logic[1:0] force_state_e (IDLE, FORCED, TIMED).
  - localparam FORCE_CNT_W_DEFAULT = 8.
- Sub-module force_hold_timer: load, decrement, expire pulse, CNT_W-parameterized. Everything else stays inline.

Test Plan:
- NET, W=4, drv=4'b0101; FORCE mask=4'b1111 value=4'b0111 → out=4'b0111 next cycle. FORCE value=4'b1111 → 4'b1111. RELEASE_ALL → 4'b0101.
- NET: FORCE mask=4'b0011 value=4'b0010 → out=4'b0110, forced_mask=4'b0011. RELEASE mask=4'b0001 → 4'b0111. RELEASE_ALL → 4'b0101. Changing drv to 4'b1000 while bits[1:0] are forced → out=4'b1010 in the same cycle.
- VAR: write 32'h1538 → out=32'h1538. FORCE all value=32'h0888 → 32'h0888. RELEASE_ALL → 32'h0888 held. Next drv_we 32'h5432 → 32'h5432.
- RELEASE mask=4'b1111 with nothing forced → out unchanged (32'h1538 in VAR; drv in NET), state stays IDLE.
- Timed: FORCE mask=4'b1000 value=4'b1000 hold=3 → out[3]=1 and timer_busy=1 for 3 cycles, then out[3]=drv[3] and state=IDLE. A second FORCE hold=3 at count 1 extends the force by 3 more cycles.
- Reset mid-TIMED → next cycle forced_mask=0, timer_busy=0, cmd_ready=0 while reset_l=0; in VAR, out=0.
